// File: rtl/mm_engine_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : mm_engine_arbiter
// Purpose  : Round-robin sharing of one 2x2 16.16 matrix-multiply engine among
//            NREQ requesters. Optional WAIT abort enabled by MM_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module mm_engine_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDXW    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     i_req,
  input  logic [NREQ*256-1:0] i_req_ops,
  output logic [NREQ-1:0]     o_gnt,
  output logic [NREQ-1:0]     o_resp_valid,
  output logic [127:0]        o_resp_data,
  output logic                o_resp_err,
  output logic                o_busy,
  output logic                o_eng_start,
  output logic [255:0]        o_eng_ops,
  input  logic [127:0]        i_eng_res,
  input  logic                i_eng_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [IDXW-1:0] r_ptr, w_ptr_nxt;
  logic [IDXW-1:0] r_idx, w_idx_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic [NREQ-1:0] r_resp_valid, w_resp_valid_nxt;
  logic [127:0]    r_resp_data, w_resp_data_nxt;
  logic            r_resp_err, w_resp_err_nxt;
  logic            r_busy;
  logic            r_eng_start, w_eng_start_nxt;
  logic [255:0]    r_eng_ops, w_eng_ops_nxt;

  logic [255:0]    w_ops [NREQ];
  logic            w_found;
  logic [IDXW-1:0] w_sel;
  logic [IDXW:0]   w_sum;
  logic            w_timeout;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ops
      assign w_ops[gi] = i_req_ops[gi*256 +: 256];
    end
  endgenerate

`ifdef MM_ARB_TIMEOUT_EN
  localparam int c_CNTW = $clog2(TIMEOUT + 1);
  logic [c_CNTW-1:0] r_to_cnt;

  // Counter is zero on entry to WAIT because it is cleared in every other state.
  always_ff @(posedge clk) begin
    if (rst)
      r_to_cnt <= '0;
    else if (r_state != S_WAIT)
      r_to_cnt <= '0;
    else if (!i_eng_done)
      r_to_cnt <= r_to_cnt + c_CNTW'(1);
  end

  assign w_timeout = (r_state == S_WAIT) && !i_eng_done &&
                     (r_to_cnt == c_CNTW'(TIMEOUT - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
  assign w_timeout        = 1'b0;
`endif

  // First set request at or above the pointer, wrapping modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_sum   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sum = {1'b0, r_ptr} + (IDXW+1)'(i);
      if (w_sum >= (IDXW+1)'(NREQ))
        w_sum = w_sum - (IDXW+1)'(NREQ);
      if (!w_found && i_req[w_sum[IDXW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_sum[IDXW-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_idx_nxt        = r_idx;
    w_gnt_nxt        = '0;
    w_resp_valid_nxt = '0;
    w_resp_data_nxt  = r_resp_data;
    w_resp_err_nxt   = r_resp_err;
    w_eng_start_nxt  = 1'b0;
    w_eng_ops_nxt    = r_eng_ops;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt      = S_ISSUE;
          w_idx_nxt        = w_sel;
          w_eng_ops_nxt    = w_ops[w_sel];
          w_gnt_nxt[w_sel] = 1'b1;
        end
      end
      S_ISSUE: begin
        w_state_nxt     = S_WAIT;
        w_eng_start_nxt = 1'b1;
      end
      S_WAIT: begin
        if (i_eng_done) begin
          w_state_nxt             = S_RESP;
          w_resp_data_nxt         = i_eng_res;
          w_resp_err_nxt          = 1'b0;
          w_resp_valid_nxt[r_idx] = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt             = S_RESP;
          w_resp_data_nxt         = '0;
          w_resp_err_nxt          = 1'b1;
          w_resp_valid_nxt[r_idx] = 1'b1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
        w_ptr_nxt   = (r_idx == IDXW'(NREQ - 1)) ? '0 : r_idx + IDXW'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_idx        <= '0;
      r_gnt        <= '0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
      r_resp_err   <= 1'b0;
      r_busy       <= 1'b0;
      r_eng_start  <= 1'b0;
      r_eng_ops    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_idx        <= w_idx_nxt;
      r_gnt        <= w_gnt_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_data  <= w_resp_data_nxt;
      r_resp_err   <= w_resp_err_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_eng_start  <= w_eng_start_nxt;
      r_eng_ops    <= w_eng_ops_nxt;
    end
  end

  assign o_gnt        = r_gnt;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_data  = r_resp_data;
  assign o_resp_err   = r_resp_err;
  assign o_busy       = r_busy;
  assign o_eng_start  = r_eng_start;
  assign o_eng_ops    = r_eng_ops;

endmodule
`default_nettype wire

// File: tb/tb_mm_engine_arbiter.sv
`default_nettype none
// tb_mm_engine_arbiter: directed bench for mm_engine_arbiter with a behavioural
// 2x2 16.16 engine that answers LAT cycles after each start pulse.
module tb_mm_engine_arbiter;
  localparam int NREQ    = 4;
  localparam int IDXW    = 2;
  localparam int TIMEOUT = 16;
  localparam int LAT     = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*256-1:0] req_ops = '0;
  logic [NREQ-1:0]     gnt, resp_valid;
  logic [127:0]        resp_data;
  logic                resp_err, busy, eng_start;
  logic [255:0]        eng_ops;
  logic [127:0]        eng_res = '0;
  logic                eng_done;
  logic                m_done = 1'b0;
  logic                tb_done = 1'b0;
  logic                eng_mute = 1'b0;
  int                  m_cnt = 0;
  int                  n_checks = 0;
  int                  n_fail = 0;
  int                  start_cnt = 0;
  int                  overlap_cnt = 0;
  logic                outstanding = 1'b0;

  always #5 clk = ~clk;

  assign eng_done = m_done | tb_done;

  mm_engine_arbiter #(.NREQ(NREQ), .IDXW(IDXW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .i_req(req), .i_req_ops(req_ops),
    .o_gnt(gnt), .o_resp_valid(resp_valid), .o_resp_data(resp_data),
    .o_resp_err(resp_err), .o_busy(busy), .o_eng_start(eng_start),
    .o_eng_ops(eng_ops), .i_eng_res(eng_res), .i_eng_done(eng_done)
  );

  function automatic logic [31:0] dot(input logic [31:0] x1, input logic [31:0] y1,
                                      input logic [31:0] x2, input logic [31:0] y2);
    longint p1, p2, s;
    p1 = longint'($signed(x1)) * longint'($signed(y1));
    p2 = longint'($signed(x2)) * longint'($signed(y2));
    s  = (p1 + p2) >>> 16;
    return s[31:0];
  endfunction

  function automatic logic [127:0] mm_mul(input logic [255:0] o);
    return {dot(o[255:224], o[127:96], o[223:192], o[63:32]),
            dot(o[255:224], o[95:64],  o[223:192], o[31:0]),
            dot(o[191:160], o[127:96], o[159:128], o[63:32]),
            dot(o[191:160], o[95:64],  o[159:128], o[31:0])};
  endfunction

  function automatic logic [255:0] mk(input logic [31:0] a11, input logic [31:0] a12,
                                      input logic [31:0] a21, input logic [31:0] a22,
                                      input logic [31:0] b11, input logic [31:0] b12,
                                      input logic [31:0] b21, input logic [31:0] b22);
    return {a11, a12, a21, a22, b11, b12, b21, b22};
  endfunction

  // Behavioural engine: done pulses LAT cycles after the start cycle.
  always @(posedge clk) begin
    m_done <= 1'b0;
    if (rst)
      m_cnt <= 0;
    else if (eng_start && !eng_mute) begin
      m_cnt   <= LAT - 1;
      eng_res <= mm_mul(eng_ops);
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_done <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (rst)
      outstanding <= 1'b0;
    else begin
      if (eng_start) begin
        start_cnt <= start_cnt + 1;
        if (outstanding) overlap_cnt <= overlap_cnt + 1;
        outstanding <= 1'b1;
      end
      if (resp_valid != '0) outstanding <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    while (gnt == '0 && n < 40) begin tick(); n++; end
  endtask

  task automatic wait_resp(input int lim, output int n);
    n = 0;
    while (resp_valid == '0 && n < lim) begin tick(); n++; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++;
    if (gnt !== '0 || resp_valid !== '0 || busy !== 1'b0 || eng_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: gnt=%b resp_valid=%b busy=%b eng_start=%b, required all 0", gnt, resp_valid, busy, eng_start);
    end
    n_checks++;
    if (resp_data !== '0 || eng_ops !== '0 || resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: resp_data=%h eng_ops=%h err=%b, required 0", resp_data, eng_ops, resp_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [255:0] ops;
    logic [127:0] exp;
    int s0, n;
    ops = mk(32'h0001_0000, 32'h0, 32'h0, 32'h0001_0000,
             32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 32'h0005_0000);
    exp = {32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 32'h0005_0000};
    s0 = start_cnt;
    req_ops[0 +: 256] = ops;
    req = 4'b0001;
    tick();
    n_checks++;
    if (gnt !== 4'b0001 || busy !== 1'b1 || eng_start !== 1'b0) begin
      n_fail++;
      $display("FAIL single_gnt: gnt=%b busy=%b start=%b, required 0001 1 0", gnt, busy, eng_start);
    end
    req = '0;
    tick();
    n_checks++;
    if (eng_start !== 1'b1 || eng_ops !== ops) begin
      n_fail++;
      $display("FAIL single_start: start=%b eng_ops=%h, required 1 %h", eng_start, eng_ops, ops);
    end
    wait_resp(40, n);
    n_checks++;
    if (n !== 4) begin
      n_fail++;
      $display("FAIL single_latency: %0d cycles after start, required 4", n);
    end
    n_checks++;
    if (resp_valid !== 4'b0001 || resp_data !== exp || resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL single_resp: valid=%b data=%h err=%b, required 0001 %h 0", resp_valid, resp_data, resp_err, exp);
    end
    n_checks++;
    if (start_cnt - s0 !== 1) begin
      n_fail++;
      $display("FAIL single_starts: %0d start pulses, required 1", start_cnt - s0);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || resp_valid !== '0 || resp_data !== exp) begin
      n_fail++;
      $display("FAIL single_after: busy=%b valid=%b data=%h, required 0 0000 %h", busy, resp_valid, resp_data, exp);
    end
  endtask

  task automatic test_simultaneous();
    logic [255:0] ops [NREQ];
    logic [NREQ-1:0] oh;
    int s0, ov0, n;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      ops[k] = mk(32'(k + 1) << 16, 32'h0000_8000, 32'hFFFF_0000, 32'(k + 2) << 16,
                  32'h0003_0000, 32'(k) << 16, 32'h0001_8000, 32'hFFFE_0000);
      req_ops[k*256 +: 256] = ops[k];
    end
    s0 = start_cnt; ov0 = overlap_cnt;
    req = 4'b1111;
    for (int k = 0; k < NREQ; k++) begin
      oh = 4'b0001 << k;
      wait_gnt(n);
      n_checks++;
      if (gnt !== oh) begin
        n_fail++;
        $display("FAIL simul_gnt%0d: gnt=%b after %0d cycles, required %b", k, gnt, n, oh);
      end
      req[k] = 1'b0;
      wait_resp(40, n);
      n_checks++;
      if (resp_valid !== oh || resp_data !== mm_mul(ops[k]) || resp_err !== 1'b0) begin
        n_fail++;
        $display("FAIL simul_resp%0d: valid=%b data=%h err=%b, required %b %h 0", k, resp_valid, resp_data, resp_err, oh, mm_mul(ops[k]));
      end
    end
    n_checks++;
    if (start_cnt - s0 !== 4 || overlap_cnt !== ov0) begin
      n_fail++;
      $display("FAIL simul_starts: %0d starts %0d overlaps, required 4 0", start_cnt - s0, overlap_cnt - ov0);
    end
  endtask

  task automatic test_round_robin();
    int n;
    req_ops[1*256 +: 256] = mk(32'h0001_0000, 0, 0, 32'h0001_0000, 32'h7, 32'h8, 32'h9, 32'hA);
    req = 4'b0010;
    wait_gnt(n);
    n_checks++;
    if (gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL rr_first: gnt=%b, required 0010", gnt);
    end
    req = '0;
    wait_resp(40, n);
    req = 4'b1001;
    wait_gnt(n);
    n_checks++;
    if (gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL rr_wrap3: gnt=%b, required 1000", gnt);
    end
    req[3] = 1'b0;
    wait_resp(40, n);
    n_checks++;
    if (resp_valid !== 4'b1000) begin
      n_fail++;
      $display("FAIL rr_resp3: valid=%b, required 1000", resp_valid);
    end
    wait_gnt(n);
    n_checks++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL rr_then0: gnt=%b, required 0001", gnt);
    end
    req[0] = 1'b0;
    wait_resp(40, n);
    n_checks++;
    if (resp_valid !== 4'b0001) begin
      n_fail++;
      $display("FAIL rr_resp0: valid=%b, required 0001", resp_valid);
    end
  endtask

  task automatic test_late_operand();
    logic [255:0] x, y;
    int n;
    x = mk(32'h0002_0000, 32'h0001_0000, 32'h0000_4000, 32'hFFFF_0000,
           32'h0001_0000, 32'h0003_0000, 32'h0005_0000, 32'h0000_8000);
    y = mk(32'h0010_0000, 32'h0, 32'h0, 32'h0010_0000,
           32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
    req_ops[1*256 +: 256] = x;
    req = 4'b0010;
    wait_gnt(n);
    n_checks++;
    if (gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL late_gnt: gnt=%b, required 0010", gnt);
    end
    req = '0;
    req_ops[1*256 +: 256] = y;
    tick();
    n_checks++;
    if (eng_ops !== x || eng_start !== 1'b1) begin
      n_fail++;
      $display("FAIL late_ops: eng_ops=%h start=%b, required %h 1", eng_ops, eng_start, x);
    end
    wait_resp(40, n);
    n_checks++;
    if (resp_valid !== 4'b0010 || resp_data !== mm_mul(x)) begin
      n_fail++;
      $display("FAIL late_resp: valid=%b data=%h, required 0010 %h", resp_valid, resp_data, mm_mul(x));
    end
  endtask

  task automatic test_reset_mid_wait();
    int n, bad;
    req_ops[2*256 +: 256] = mk(32'h0001_0000, 0, 0, 32'h0001_0000, 32'h1, 32'h2, 32'h3, 32'h4);
    req_ops[0 +: 256]     = mk(32'h0003_0000, 0, 0, 32'h0001_0000, 32'h11, 32'h12, 32'h13, 32'h14);
    req = 4'b0100;
    wait_gnt(n);
    n_checks++;
    if (gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL rstw_gnt: gnt=%b, required 0100", gnt);
    end
    req = '0;
    tick(); tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (gnt !== '0 || resp_valid !== '0 || busy !== 1'b0 || eng_start !== 1'b0 ||
        resp_data !== '0 || eng_ops !== '0 || resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rstw_outputs: gnt=%b valid=%b busy=%b start=%b data=%h ops=%h err=%b, required all 0",
               gnt, resp_valid, busy, eng_start, resp_data, eng_ops, resp_err);
    end
    rst = 1'b0;
    tick();
    tb_done = 1'b1;
    tick();
    tb_done = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (resp_valid !== '0 || busy !== 1'b0) bad++;
      tick();
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL rstw_late_done: %0d cycles with resp_valid or busy, required 0", bad);
    end
    req = 4'b0101;
    wait_gnt(n);
    n_checks++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL rstw_ptr: gnt=%b, required 0001", gnt);
    end
    req[0] = 1'b0;
    wait_resp(40, n);
    wait_gnt(n);
    req = '0;
    wait_resp(40, n);
    n_checks++;
    if (resp_valid !== 4'b0100 || resp_data !== {32'h1, 32'h2, 32'h3, 32'h4}) begin
      n_fail++;
      $display("FAIL rstw_resp2: valid=%b data=%h, required 0100 %h", resp_valid, resp_data, {32'h1, 32'h2, 32'h3, 32'h4});
    end
  endtask

  task automatic test_timeout();
    int n, bad;
    eng_mute = 1'b1;
    req = 4'b1000;
    wait_gnt(n);
    n_checks++;
    if (gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL to_gnt: gnt=%b, required 1000", gnt);
    end
    req = '0;
`ifdef MM_ARB_TIMEOUT_EN
    wait_resp(60, n);
    n_checks++;
    if (n !== TIMEOUT + 1 || resp_valid !== 4'b1000 || resp_err !== 1'b1 || resp_data !== '0) begin
      n_fail++;
      $display("FAIL to_abort: n=%0d valid=%b err=%b data=%h, required %0d 1000 1 0", n, resp_valid, resp_err, resp_data, TIMEOUT + 1);
    end
`else
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (busy !== 1'b1 || resp_valid !== '0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL to_hang: %0d cycles not busy or with resp_valid, required 0", bad);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL to_recover: busy=%b, required 0", busy);
    end
`endif
    eng_mute = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_round_robin();
    test_late_operand();
    test_reset_mid_wait();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
